// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_pkg
//  Description : Shared definitions for the instruction-fetch stage: bus
//                widths, bytes per instruction, zero word and the 2-bit
//                fetch state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package inst_fetch_pkg;

   localparam int INST_ADDR_BUS  = 32;
   localparam int INST_BUS       = 32;
   localparam int BYTES_PER_INST = 4;

   localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : inst_byte_assembler
//  Description : Collects the bytes of one instruction into little-endian
//                lanes and counts responses that must be thrown away after
//                a redirect.
//  Ports       : clear        - restart byte collection at lane 0
//                byte_valid   - byte_data belongs to the current word
//                byte_data    - incoming byte
//                drain_load   - load drain_count into the discard counter
//                drain_count  - number of responses still in flight
//                drain_valid  - one in-flight response arrived (discarded)
//                recv_cnt     - bytes collected so far
//                word_ready   - the last byte of the word arrives this cycle
//                drain_done   - the last in-flight response arrives this cycle
//                word         - assembled instruction word
//  Revision    : 1.0  initial release
// ============================================================================
module inst_byte_assembler
   import inst_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic        drain_load,
   input  logic [2:0]  drain_count,
   input  logic        drain_valid,
   output logic [2:0]  recv_cnt,
   output logic        word_ready,
   output logic        drain_done,
   output logic [INST_BUS-1:0] word
);

   logic [BYTES_PER_INST-1:0][7:0] lanes;
   logic [2:0]                     pending;

   assign word       = lanes;
   assign word_ready = byte_valid && (recv_cnt == 3'(BYTES_PER_INST - 1));
   assign drain_done = drain_valid && (pending == 3'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes    <= ZERO_WORD;
         recv_cnt <= 3'd0;
         pending  <= 3'd0;
      end else begin
         if (clear) begin
            recv_cnt <= 3'd0;
         end else if (byte_valid) begin
            lanes[recv_cnt[1:0]] <= byte_data;
            recv_cnt             <= recv_cnt + 3'd1;
         end

         if (drain_load) begin
            pending <= drain_count;
         end else if (drain_valid && (pending != 3'd0)) begin
            pending <= pending - 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction-fetch stage in front of a direct-mapped I-cache.
//                Hits are delivered on the next edge; misses read four bytes
//                from the byte-wide memory controller, fill the cache and
//                deliver the word. Supports stall and jump redirect, including
//                redirect with byte reads still in flight.
//  Ports       : stall_i/jump_i/jump_addr_i     - pipeline control
//                cache_query_o/query_addr_o     - cache lookup
//                inst_hit_i/inst_cache_i        - cache lookup response
//                cache_enable_o/addr/data       - cache fill
//                mem_req_o/mem_addr_o/mem_grant_i/mem_valid_i/mem_data_i
//                                               - byte memory interface
//                if_valid_o/if_pc_o/if_inst_o   - IF/ID output
//  Revision    : 1.0  initial release
// ============================================================================
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                ADDR_W   = INST_ADDR_BUS,
   parameter int                INST_W   = INST_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              cache_query_o,
   output logic [ADDR_W-1:0] query_addr_o,
   input  logic              inst_hit_i,
   input  logic [INST_W-1:0] inst_cache_i,
   output logic              cache_enable_o,
   output logic [ADDR_W-1:0] cache_addr_o,
   output logic [INST_W-1:0] cache_data_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_grant_i,
   input  logic              mem_valid_i,
   input  logic [7:0]        mem_data_i,
   output logic              if_valid_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o
);

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        issue_cnt, issue_next, recv_cnt, recv_next, drain_count;
   logic              done_written;
   logic              grant, fetch_byte, drain_byte;
   logic              word_ready, drain_done;
   logic              clear_cnt, drain_load, deliver, drop_valid;
   logic [INST_W-1:0] deliver_inst;
   logic [INST_BUS-1:0] word;

   // Lookup is suppressed during reset so every output reads 0 immediately.
   assign cache_query_o  = !rst && (state == S_IDLE) && !stall_i;
   assign query_addr_o   = pc;
   assign mem_req_o      = (state == S_FETCH) && (issue_cnt < 3'(BYTES_PER_INST));
   assign mem_addr_o     = pc + ADDR_W'(issue_cnt);
   // The fill happens once, even if DONE is held for several stalled cycles.
   assign cache_enable_o = (state == S_DONE) && !done_written;
   assign cache_addr_o   = pc;
   assign cache_data_o   = INST_W'(word);

   assign grant      = mem_req_o && mem_grant_i;
   assign fetch_byte = (state == S_FETCH) && mem_valid_i;
   assign drain_byte = (state == S_DRAIN) && mem_valid_i;
   // Post-edge counts: a grant or response coinciding with a jump is included,
   // so pending covers exactly the bytes still to come back.
   assign issue_next  = issue_cnt + {2'd0, grant};
   assign recv_next   = recv_cnt + {2'd0, fetch_byte};
   assign drain_count = issue_next - recv_next;

   inst_byte_assembler u_assembler (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear_cnt),
      .byte_valid  (fetch_byte),
      .byte_data   (mem_data_i),
      .drain_load  (drain_load),
      .drain_count (drain_count),
      .drain_valid (drain_byte),
      .recv_cnt    (recv_cnt),
      .word_ready  (word_ready),
      .drain_done  (drain_done),
      .word        (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      clear_cnt    = 1'b0;
      drain_load   = 1'b0;
      deliver      = 1'b0;
      drop_valid   = 1'b0;
      deliver_inst = inst_cache_i;

      case (state)
         S_IDLE: begin
            if (!stall_i) begin
               if (inst_hit_i) begin
                  deliver = 1'b1;
               end else begin
                  state_next = S_FETCH;
                  clear_cnt  = 1'b1;
                  drop_valid = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (word_ready) begin
               state_next = S_DONE;
            end
         end
         S_DRAIN: begin
            if (drain_done) begin
               state_next = S_IDLE;
            end
         end
         S_DONE: begin
            if (!stall_i) begin
               deliver      = 1'b1;
               deliver_inst = INST_W'(word);
               state_next   = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Redirect overrides everything except an ongoing drain.
      if (jump_i) begin
         deliver    = 1'b0;
         drop_valid = 1'b1;
         clear_cnt  = 1'b0;
         case (state)
            S_FETCH: begin
               if (drain_count != 3'd0) begin
                  state_next = S_DRAIN;
                  drain_load = 1'b1;
               end else begin
                  state_next = S_IDLE;
               end
            end
            S_DRAIN: state_next = drain_done ? S_IDLE : S_DRAIN;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= RESET_PC;
         issue_cnt    <= 3'd0;
         done_written <= 1'b0;
         if_valid_o   <= 1'b0;
         if_pc_o      <= '0;
         if_inst_o    <= '0;
      end else begin
         done_written <= (state == S_DONE);

         if (clear_cnt) begin
            issue_cnt <= 3'd0;
         end else begin
            issue_cnt <= issue_next;
         end

         if (jump_i) begin
            pc         <= jump_addr_i;
            if_valid_o <= 1'b0;
         end else if (deliver) begin
            if_valid_o <= 1'b1;
            if_inst_o  <= deliver_inst;
            if_pc_o    <= pc;
            pc         <= pc + ADDR_W'(BYTES_PER_INST);
         end else if (drop_valid) begin
            if_valid_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Randomized scoreboard bench for inst_fetch. A byte memory
//                with a fixed content function, a cache model and a
//                program-order model of expected deliveries are kept here.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          NCYC   = 3000;

   logic        clk, rst;
   logic        stall_i, jump_i;
   logic [31:0] jump_addr_i;
   logic        cache_query_o;
   logic [31:0] query_addr_o;
   logic        inst_hit_i;
   logic [31:0] inst_cache_i;
   logic        cache_enable_o;
   logic [31:0] cache_addr_o, cache_data_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_grant_i, mem_valid_i;
   logic [7:0]  mem_data_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o, if_inst_o;

   inst_fetch #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i),
      .jump_addr_i(jump_addr_i), .cache_query_o(cache_query_o),
      .query_addr_o(query_addr_o), .inst_hit_i(inst_hit_i),
      .inst_cache_i(inst_cache_i), .cache_enable_o(cache_enable_o),
      .cache_addr_o(cache_addr_o), .cache_data_o(cache_data_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_grant_i(mem_grant_i), .mem_valid_i(mem_valid_i),
      .mem_data_i(mem_data_i), .if_valid_o(if_valid_o),
      .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int deliveries = 0;

   // Byte memory content: fixed function of the byte address.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] lo, hi;
      lo = a[7:0];
      hi = a[15:8];
      return (lo * 8'd37) ^ hi ^ 8'hA5;
   endfunction

   // Instruction at pc: bytes pc..pc+3 assembled little-endian.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
              mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   logic [31:0] cache_m [logic [31:0]];  // cache model: filled words
   logic [31:0] pend_q [$];               // granted byte addresses in flight
   logic [31:0] exp_q [$];                // next expected delivered pc(s)

   // ---------------- monitor: delivered instruction checking ----------------
   logic        exp_valid = 1'b0;
   logic [31:0] exp_pc = '0, exp_inst = '0;
   int          idle_cycles = 0;

   always @(posedge clk) begin : monitor
      logic st_e, jp_e, rs_e;
      st_e = stall_i;
      jp_e = jump_i;
      rs_e = rst;
      #1;
      if (rs_e || rst) begin
         exp_valid   = 1'b0;
         idle_cycles = 0;
      end else if (jp_e) begin
         check32("valid_after_jump", {31'd0, if_valid_o}, 32'd0);
         exp_valid = 1'b0;
      end else if (st_e) begin
         check32("stall_hold_valid", {31'd0, if_valid_o}, {31'd0, exp_valid});
         if (exp_valid) begin
            check32("stall_hold_pc", if_pc_o, exp_pc);
            check32("stall_hold_inst", if_inst_o, exp_inst);
         end
      end else if (if_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL deliver_unexpected actual_pc=%h expected=none", if_pc_o);
         end else begin
            exp_pc   = exp_q.pop_front();
            exp_inst = mem_word(exp_pc);
            check32("deliver_pc", if_pc_o, exp_pc);
            check32("deliver_inst", if_inst_o, exp_inst);
            if (exp_q.size() == 0) exp_q.push_back(exp_pc + 32'd4);
         end
         exp_valid   = 1'b1;
         deliveries++;
         idle_cycles = 0;
      end else begin
         exp_valid = 1'b0;
      end

      if (!rst) begin
         idle_cycles++;
         if (idle_cycles > 300) begin
            checks++;
            failures++;
            $display("FAIL progress_timeout actual=%0d_idle_cycles required<=300", idle_cycles);
            idle_cycles = 0;
         end
      end
   end

   // ---------------- driver: stimulus and memory/cache models ----------------
   task automatic check_outputs_zero(input string tag);
      check32({tag, "_if_valid"}, {31'd0, if_valid_o}, 32'd0);
      check32({tag, "_if_pc"}, if_pc_o, 32'd0);
      check32({tag, "_if_inst"}, if_inst_o, 32'd0);
      check32({tag, "_mem_req"}, {31'd0, mem_req_o}, 32'd0);
      check32({tag, "_cache_en"}, {31'd0, cache_enable_o}, 32'd0);
      check32({tag, "_cache_query"}, {31'd0, cache_query_o}, 32'd0);
   endtask

   initial begin : driver
      logic force_miss, grant_en, mid_reset_done;
      rst = 1'b1;
      stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
      inst_hit_i = 1'b0; inst_cache_i = '0;
      mem_grant_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
      mid_reset_done = 1'b0;
      exp_q.push_back(RST_PC);
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc != 0) @(negedge clk);
         if (cyc < 60) begin
            // quiet phase: always grant and respond, no stall or jump
            stall_i = 1'b0; jump_i = 1'b0;
            force_miss = 1'b0; grant_en = 1'b1;
            mem_valid_i = (pend_q.size() != 0);
         end else begin
            stall_i    = ($urandom_range(0, 3) == 0);
            jump_i     = ($urandom_range(0, 15) == 0);
            force_miss = ($urandom_range(0, 2) == 0);
            grant_en   = ($urandom_range(0, 2) != 0);
            mem_valid_i = (pend_q.size() != 0) && ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0)
               jump_addr_i = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            else
               jump_addr_i = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         end
         mem_data_i = mem_valid_i ? mem_byte(pend_q[0]) : 8'h00;

         #1;
         inst_hit_i   = 1'b0;
         inst_cache_i = '0;
         if (cache_query_o && !force_miss && cache_m.exists(query_addr_o)) begin
            inst_hit_i   = 1'b1;
            inst_cache_i = cache_m[query_addr_o];
         end
         mem_grant_i = mem_req_o && grant_en;

         #1;
         if (mem_req_o && mem_grant_i) pend_q.push_back(mem_addr_o);
         if (mem_valid_i) void'(pend_q.pop_front());
         if (cache_enable_o) begin
            check32("cache_fill_data", cache_data_o, mem_word(cache_addr_o));
            cache_m[cache_addr_o] = cache_data_o;
         end
         if (jump_i) begin
            exp_q.delete();
            exp_q.push_back(jump_addr_i);
         end

         // asynchronous reset between edges while a miss is being fetched
         if (!mid_reset_done && cyc > 1500 && mem_req_o) begin
            mid_reset_done = 1'b1;
            #1;
            rst = 1'b1;
            #1;
            check_outputs_zero("async_reset");
            pend_q.delete();
            exp_q.delete();
            exp_q.push_back(RST_PC);
            @(negedge clk);
            stall_i = 1'b0; jump_i = 1'b0;
            mem_valid_i = 1'b0; mem_grant_i = 1'b0; inst_hit_i = 1'b0;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      @(negedge clk);
      checks++;
      if (deliveries < 100) begin
         failures++;
         $display("FAIL delivery_count actual=%0d required>=100", deliveries);
      end
      checks++;
      if (!mid_reset_done) begin
         failures++;
         $display("FAIL mid_fetch_reset actual=not_reached required=reached");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
